// File: rtl/fp_pkg.sv
// Shared types and helpers for the single-precision
// stream summing block.
package fp_pkg;

   typedef enum logic [1:0] {
      COLLECT0,
      COLLECT1,
      ADD,
      DONE
   } state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   // Effective exponent: subnormals and zero use 1.
   function automatic logic [7:0] fp_exp(input logic [31:0] x);
      return (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
   endfunction

   function automatic logic [23:0] fp_man(input logic [31:0] x);
      return {x[30:23] != 8'd0, x[22:0]};
   endfunction

endpackage

// File: rtl/fp_adder3.sv
// Combinational three-operand IEEE-754 single adder,
// round to nearest even.
module fp_adder3
   import fp_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   output logic [31:0] sum
);

   logic [31:0] ops [3];
   logic [7:0]  emax;
   logic [7:0]  d;
   logic [49:0] ext;
   logic [49:0] al;
   logic [52:0] acc;
   logic [51:0] mag;
   logic [49:0] nrm;
   logic [23:0] frac;
   logic [24:0] rnd;
   logic        sticky;
   logic        neg;
   logic        g;
   logic        st;
   logic        inc;
   logic        any_nan;
   logic        pos_inf;
   logic        neg_inf;
   int          p;
   int          ei;
   int          sh;

   assign ops[0] = a;
   assign ops[1] = b;
   assign ops[2] = c;

   always_comb begin
      emax    = 8'd1;
      any_nan = 1'b0;
      pos_inf = 1'b0;
      neg_inf = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (fp_exp(ops[i]) > emax)
            emax = fp_exp(ops[i]);
         if (ops[i][30:23] == 8'hFF) begin
            if (ops[i][22:0] != 23'd0)
               any_nan = 1'b1;
            else if (ops[i][31])
               neg_inf = 1'b1;
            else
               pos_inf = 1'b1;
         end
      end
   end

   // Align to emax; shifted-out bits only feed sticky.
   always_comb begin
      acc    = '0;
      sticky = 1'b0;
      d      = '0;
      ext    = '0;
      al     = '0;
      for (int i = 0; i < 3; i++) begin
         d   = emax - fp_exp(ops[i]);
         ext = {fp_man(ops[i]), 26'd0};
         if (d >= 8'd50) begin
            al     = '0;
            sticky = sticky | (|ext);
         end else begin
            al     = ext >> d;
            sticky = sticky | ((al << d) != ext);
         end
         if (ops[i][31])
            acc = acc - {3'd0, al};
         else
            acc = acc + {3'd0, al};
      end
   end

   always_comb begin
      neg = acc[52];
      mag = neg ? 52'(-acc) : acc[51:0];
      p   = 0;
      for (int k = 0; k < 52; k++)
         if (mag[k])
            p = k;
      ei  = int'(emax) + p - 49;
      sh  = 0;
      st  = sticky;
      if (p > 49) begin
         sh  = p - 49;
         nrm = 50'(mag >> sh);
         st  = st | (({2'b00, nrm} << sh) != mag);
      end else if (ei < 1) begin
         sh  = int'(emax) - 1;
         nrm = 50'(mag << sh);
         ei  = 1;
      end else begin
         sh  = 49 - p;
         nrm = 50'(mag << sh);
      end
      frac = nrm[49:26];
      g    = nrm[25];
      st   = st | (|nrm[24:0]);
      inc  = g & (st | frac[0]);
      rnd  = {1'b0, frac} + {24'd0, inc};
      if (rnd[24])
         ei = ei + 1;

      if (any_nan || (pos_inf && neg_inf))
         sum = 32'h7FC0_0000;
      else if (pos_inf)
         sum = 32'h7F80_0000;
      else if (neg_inf)
         sum = 32'hFF80_0000;
      else if (mag == '0)
         sum = FP_ZERO;
      else if (ei >= 255)
         sum = {neg, 8'hFF, 23'd0};
      else if (rnd[24])
         sum = {neg, 8'(ei), 23'd0};
      else if (rnd[23])
         sum = {neg, 8'(ei), rnd[22:0]};
      else
         sum = {neg, 8'd0, rnd[22:0]};
   end

endmodule

// File: rtl/fp_sum3_ctrl.sv
// Reduces a valid/ready float stream to one sum,
// two elements per add cycle.
module fp_sum3_ctrl
   import fp_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   state_t           state;
   logic [31:0]      acc;
   logic [31:0]      op0;
   logic [31:0]      op1;
   logic [31:0]      acc_opd;
   logic [31:0]      add_sum;
   logic             acc_vld;
   logic             op1_pad;
   logic             last_f;
   logic [CNT_W-1:0] cnt;
   logic             xfer;

   assign xfer      = in_valid && in_ready;
   assign acc_opd   = acc_vld ? acc : FP_ZERO;
   assign out_data  = acc;
   assign out_count = cnt;

   // Padding with FP_ZERO is exact only when the
   // largest operand exponent is >= 27; not corrected.
   fp_adder3 u_add (
      .a   (acc_opd),
      .b   (op0),
      .c   (op1),
      .sum (add_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT0;
         acc       <= FP_ZERO;
         acc_vld   <= 1'b0;
         op0       <= '0;
         op1       <= '0;
         op1_pad   <= 1'b0;
         last_f    <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (xfer)
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
         unique case (state)
            COLLECT0: begin
               if (xfer) begin
                  op0  <= in_data;
                  busy <= 1'b1;
                  if (in_last) begin
                     op1      <= FP_ZERO;
                     op1_pad  <= 1'b1;
                     last_f   <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= ADD;
                  end else begin
                     state <= COLLECT1;
                  end
               end
            end
            COLLECT1: begin
               if (xfer) begin
                  op1      <= in_data;
                  op1_pad  <= 1'b0;
                  last_f   <= in_last;
                  in_ready <= 1'b0;
                  state    <= ADD;
               end
            end
            ADD: begin
               // Bypass keeps a lone element bit-exact.
               acc     <= (!acc_vld && op1_pad) ? op0 : add_sum;
               acc_vld <= 1'b1;
               if (last_f) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  in_ready <= 1'b1;
                  state    <= COLLECT0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  acc       <= FP_ZERO;
                  acc_vld   <= 1'b0;
                  cnt       <= '0;
                  last_f    <= 1'b0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= COLLECT0;
               end
            end
            default: state <= COLLECT0;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sum3_ctrl.sv
// Directed bench for fp_sum3_ctrl: known float sums,
// latency, output hold and mid-stream reset.
module tb_fp_sum3_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_count;
   logic        busy;

   int errs   = 0;
   int checks = 0;

   fp_sum3_ctrl #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Entered and left on a falling edge.
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_rdy", {31'd0, in_ready}, 32'd1);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 32'hDEAD_BEEF;
   endtask

   // Called on the falling edge right after the last accept.
   task automatic finish(input string tag,
                         input logic [31:0] d,
                         input logic [15:0] n);
      check({tag, "_add_ov"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_add_rdy"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, out_data, d);
      check({tag, "_cnt"}, {16'd0, out_count}, {16'd0, n});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ov_clr"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
      check({tag, "_cnt_clr"}, {16'd0, out_count}, 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ov", {31'd0, out_valid}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_cnt", {16'd0, out_count}, 32'd0);
      check("rst_rdy", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1 + 2 + 3
      send(32'h3F80_0000, 1'b0);
      check("s1_busy", {31'd0, busy}, 32'd1);
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b1);
      finish("s1", 32'h40C0_0000, 16'd3);

      // 1 + 2 + 3 + 4
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b0);
      send(32'h4080_0000, 1'b1);
      finish("s2", 32'h4120_0000, 16'd4);

      // single element bypass
      send(32'h40A0_0000, 1'b1);
      finish("s3", 32'h40A0_0000, 16'd1);

      // 1 + (-3)
      send(32'h3F80_0000, 1'b0);
      send(32'hC040_0000, 1'b1);
      finish("s4", 32'hC000_0000, 16'd2);

      // result held under back-pressure: 2 + 3
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("hold_ov", {31'd0, out_valid}, 32'd1);
         check("hold_data", out_data, 32'h40A0_0000);
         check("hold_cnt", {16'd0, out_count}, 32'd2);
         check("hold_rdy", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("hold_done", {31'd0, out_valid}, 32'd0);

      // reset mid-stream
      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      rst = 1'b1;
      #1;
      check("mrst_rdy", {31'd0, in_ready}, 32'd1);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_cnt", {16'd0, out_count}, 32'd0);
      check("mrst_ov", {31'd0, out_valid}, 32'd0);
      check("mrst_data", out_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(32'h4000_0000, 1'b1);
      finish("s5", 32'h4000_0000, 16'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fp_sum3_ctrl.md
FP_SUM3_CTRL -- requirements
Module: fp_sum3_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the element counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 32: IEEE-754 single operand.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid.
REQ-006 SHALL have port in_last, input, 1: the current element is the final one of its stream.
REQ-007 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-008 SHALL have port out_data, output, 32: stream sum.
REQ-009 SHALL have port out_valid, output, 1: out_data and out_count are valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port out_count, output, CNT_W: number of elements in the summed stream.
REQ-012 SHALL have port busy, output, 1: high in every state except COLLECT0 with no element yet accepted in the current stream.

Function
REQ-013 SHALL reduce each stream (terminated by in_last) to one sum using one fp_adder3 instance, operands {acc, op0, op1}.
REQ-014 SHALL transfer an input element only on the rising edge where in_valid && in_ready.
REQ-015 SHALL use states COLLECT0 (no pending operand), COLLECT1 (op0 held), ADD, DONE.
REQ-016 SHALL drive in_ready = 1 in COLLECT0 and COLLECT1 and 0 in ADD and DONE.
REQ-017 In COLLECT0, SHALL on a non-last transfer capture op0 and go to COLLECT1; on a last transfer it SHALL capture op0, set op1 = FP_ZERO, and go to ADD with the last flag set.
REQ-018 In COLLECT1, SHALL on any transfer capture op1 and go to ADD; the last flag SHALL equal in_last.
REQ-019 In ADD (exactly one cycle), the acc operand SHALL be FP_ZERO when acc is empty, else acc.
REQ-020 In ADD, SHALL register the adder output into acc and mark acc non-empty.
REQ-021 Bypass: if acc is empty and op1 is padding, SHALL load acc <= op0 unchanged.
REQ-022 From ADD, SHALL go to DONE if the last flag is set, else to COLLECT0.
REQ-023 In DONE, SHALL hold out_valid = 1 with out_data = acc and out_count stable until out_ready = 1.
REQ-024 On the DONE handshake, SHALL clear acc to empty, clear the counter, and go to COLLECT0.
REQ-025 SHALL increment the counter on every transfer and saturate it at all ones.
REQ-026 Latency: out_valid SHALL assert 2 cycles after the edge that accepts the last element (ADD cycle, then DONE).
REQ-027 Throughput: SHALL accept at most 2 elements per 3 cycles.
REQ-028 In COLLECT0/1, in_data SHALL be ignored while in_valid = 0, and in_last SHALL be ignored without a transfer.
REQ-029 Exactness: zero padding SHALL be exact only when the maximum operand exponent is >= 27; this SHALL be documented, not corrected.

Reset
REQ-030 While rst = 1, SHALL immediately force: state COLLECT0, acc empty (32'h0), op0 = op1 = 0, last flag 0, counter 0.
REQ-031 Output reset values SHALL be: out_valid 0, out_data 32'h0, out_count 0, in_ready 1, busy 0.
REQ-032 Reset mid-stream SHALL discard all partial state, with no output produced for the aborted stream.

Structure
REQ-033 Shared package fp_pkg SHALL hold the state encoding and the constant FP_ZERO = 32'h00000000.
REQ-034 SHALL contain exactly one sub-module instance, fp_adder3, which is purely combinational; the ADD-cycle register SHALL sit in this block.

Verification
REQ-035 Bench SHALL drive stream 3F800000, 40000000, 40400000 (last) and require out_data 40C00000, out_count 3.
REQ-036 Bench SHALL drive stream 3F800000, 40000000, 40400000, 40800000 (last) and require out_data 41200000, out_count 4.
REQ-037 Bench SHALL drive a single element 40A00000 (last) and require bypass output 40A00000, out_count 1, 2 cycles after accept.
REQ-038 Bench SHALL drive 3F800000, C0400000 (last) and require out_data C0000000.
REQ-039 Bench SHALL hold out_ready = 0 for 5 cycles in DONE and require out_valid = 1, stable data and count, in_ready = 0 throughout.
REQ-040 Bench SHALL assert rst after 2 accepted elements, then drive 40000000 (last), and require out_data 40000000, out_count 1.
